// File: rtl/signal_ramp_pkg.sv
// Shared constants and monitor state encoding for the ramp scaler slice.
package signal_ramp_pkg;

  localparam int RAMP_UNITY = 8192;
  localparam int RAMP_FRAC  = 13;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISING  = 3'd1,
    FULL    = 3'd2,
    FALLING = 3'd3,
    DONE    = 3'd4
  } ramp_state_t;

endpackage

// File: rtl/ramp_envelope_monitor.sv
// Envelope monitor: tracks the ramp phase every cycle and flags completion
// once the ramp has sat at zero for DONE_HOLD consecutive cycles after falling.
module ramp_envelope_monitor
  import signal_ramp_pkg::*;
#(
  parameter int RAMP_WIDTH = 16,
  parameter int DONE_HOLD  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RAMP_WIDTH-1:0] ramp,
  output logic [2:0]            ramp_state,
  output logic                  ramp_done
);

  localparam int CNT_W = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
  localparam logic [RAMP_WIDTH-1:0] UNITY    = RAMP_WIDTH'(RAMP_UNITY);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DONE_HOLD - 1);

  ramp_state_t      state_q, state_d;
  logic [CNT_W-1:0] zcnt_q, zcnt_d;

  // State and zero-run counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      zcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      zcnt_q  <= zcnt_d;
    end
  end

  // Next-state logic; the zero counter only runs while falling and idle-zeroes otherwise.
  always_comb begin
    state_d = state_q;
    zcnt_d  = '0;
    case (state_q)
      IDLE: begin
        if (ramp >= UNITY)    state_d = FULL;
        else if (ramp != '0)  state_d = RISING;
      end
      RISING: begin
        if (ramp >= UNITY)    state_d = FULL;
      end
      FULL: begin
        if (ramp < UNITY)     state_d = FALLING;
      end
      FALLING: begin
        if (ramp >= UNITY) begin
          state_d = FULL;
        end else if (ramp == '0) begin
          if (zcnt_q == CNT_LAST) state_d = DONE;
          else                    zcnt_d  = zcnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (ramp != '0)       state_d = RISING;
      end
      default:                state_d = IDLE;
    endcase
  end

  assign ramp_state = state_q;
  assign ramp_done  = (state_q == DONE);

endmodule

// File: rtl/signal_ramp_scaler.sv
// Ramp-envelope scaler: multiplies a signed sample stream by a Q13 ramp word
// (8192 = unity) in a 3-stage stall-able pipeline and reports envelope phase.
// Build option: define SIGNAL_RAMP_SCALER_ROUND_EN for round-half-up scaling;
// otherwise the scaled result truncates toward minus infinity.
module signal_ramp_scaler
  import signal_ramp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int RAMP_WIDTH = 16,
  parameter int DONE_HOLD  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic        [RAMP_WIDTH-1:0] ramp,
  output logic signed [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                  [2:0]  ramp_state,
  output logic                         ramp_done
);

  localparam int P = DATA_WIDTH + RAMP_WIDTH + 1;
  localparam logic [RAMP_WIDTH-1:0] UNITY   = RAMP_WIDTH'(RAMP_UNITY);
  localparam logic signed [P-1:0]   SAT_MAX = {{(P-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [P-1:0]   SAT_MIN = {{(P-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  function automatic logic [RAMP_WIDTH-1:0] clamp_ramp(input logic [RAMP_WIDTH-1:0] r);
    return (r > UNITY) ? UNITY : r;
  endfunction

  function automatic logic signed [P-1:0] round_shift(input logic signed [P-1:0] prod);
`ifdef SIGNAL_RAMP_SCALER_ROUND_EN
    logic signed [P-1:0] half;
    half = P'(RAMP_UNITY / 2);
    return (prod + half) >>> RAMP_FRAC;
`else
    return prod >>> RAMP_FRAC;
`endif
  endfunction

  // Unreachable with a clamped ramp, kept so widening the ramp never wraps.
  function automatic logic signed [DATA_WIDTH-1:0] saturate(input logic signed [P-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[DATA_WIDTH-1:0];
    if (v < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    return v[DATA_WIDTH-1:0];
  endfunction

  logic                         advance;
  logic                         vld_p1, vld_p2, vld_p3;
  logic signed [DATA_WIDTH-1:0] data_p1;
  logic        [RAMP_WIDTH-1:0] ramp_p1;
  logic signed [P-1:0]          prod_p2;
  logic signed [DATA_WIDTH-1:0] out_p3;

  assign advance       = ~vld_p3 | m_axis_tready;
  assign s_axis_tready = advance & ~reset;

  // Valid bits move in lockstep with the data; reset flushes every in-flight beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else if (advance) begin
      vld_p1 <= s_axis_tvalid;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  // Stage 1/2 data registers.
  always_ff @(posedge clk) begin
    if (advance) begin
      // ---- stage 1: capture sample and clamped ramp ----
      data_p1 <= s_axis_tdata;
      ramp_p1 <= clamp_ramp(ramp);
      // ---- stage 2: full-precision signed product ----
      prod_p2 <= $signed({{(P-DATA_WIDTH){data_p1[DATA_WIDTH-1]}}, data_p1})
               * $signed({{(P-RAMP_WIDTH){1'b0}}, ramp_p1});
    end
  end

  // ---- stage 3: scale back to sample width; output register clears on reset ----
  always_ff @(posedge clk) begin
    if (reset)        out_p3 <= '0;
    else if (advance) out_p3 <= saturate(round_shift(prod_p2));
  end

  assign m_axis_tdata  = out_p3;
  assign m_axis_tvalid = vld_p3;

  ramp_envelope_monitor #(
    .RAMP_WIDTH (RAMP_WIDTH),
    .DONE_HOLD  (DONE_HOLD)
  ) u_monitor (
    .clk        (clk),
    .reset      (reset),
    .ramp       (ramp),
    .ramp_state (ramp_state),
    .ramp_done  (ramp_done)
  );

endmodule

// File: tb/tb_signal_ramp_scaler.sv
// Scoreboard bench for signal_ramp_scaler: accepted beats push a model result,
// an output monitor pops and compares; envelope monitor checked step by step.
`timescale 1ns/1ps
module tb_signal_ramp_scaler;

  localparam int DW = 16;
  localparam int RW = 16;
  localparam int DH = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic signed [DW-1:0] s_axis_tdata;
  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  logic        [RW-1:0] ramp;
  logic signed [DW-1:0] m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic           [2:0] ramp_state;
  logic                 ramp_done;

  always #5 clk = ~clk;

  signal_ramp_scaler #(.DATA_WIDTH(DW), .RAMP_WIDTH(RW), .DONE_HOLD(DH)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .ramp          (ramp),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .ramp_state    (ramp_state),
    .ramp_done     (ramp_done)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit lat_chk = 1'b0;

  typedef struct {
    logic signed [DW-1:0] d;
    int                   acc;
  } exp_t;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: sample * min(ramp, 8192) / 8192, floored (after +4096 when rounding).
  function automatic logic signed [DW-1:0] model(int x, int r);
    longint p, q;
    int     rc;
    rc = (r > 8192) ? 8192 : r;
    p  = longint'(x) * longint'(rc);
`ifdef SIGNAL_RAMP_SCALER_ROUND_EN
    p = p + 4096;
`endif
    q = p / 8192;
    if ((p % 8192 != 0) && (p < 0)) q = q - 1;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return DW'(q);
  endfunction

  task automatic chk(string name, longint act, longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard push: a beat is accepted at the coming rising edge.
  always @(negedge clk) begin
    if (!reset && s_axis_tvalid && s_axis_tready)
      exp_q.push_back('{model(int'(s_axis_tdata), int'(ramp)), cyc + 1});
  end

  // Output monitor: pops on every transfer and checks stall stability.
  logic                 prev_stall = 1'b0;
  logic signed [DW-1:0] prev_data  = '0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", m_axis_tvalid, 1);
        chk("stall_data", m_axis_tdata, prev_data);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %0d want no beat (cycle %0d)", m_axis_tdata, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("data", m_axis_tdata, e.d);
          if (lat_chk) chk("latency", cyc + 1 - e.acc, 3);
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
    end
  end

  task automatic send(int d, int r);
    bit acc;
    int n;
    n = 0;
    s_axis_tdata  = DW'(d);
    ramp          = RW'(r);
    s_axis_tvalid = 1'b1;
    do begin
      #1;
      acc = s_axis_tready;
      step();
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept want accept of %0d", d);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  rv[$];
    int  sv[$];
    bit  acc;
    int  sel;

    reset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; ramp = '0; m_axis_tready = 1'b1;
    repeat (3) step();
    chk("rst_mvalid", m_axis_tvalid, 0);
    chk("rst_mdata", m_axis_tdata, 0);
    chk("rst_state", ramp_state, 0);
    chk("rst_done", ramp_done, 0);
    chk("rst_sready", s_axis_tready, 0);
    reset = 1'b0;
    step();

    // Envelope sequence: ramp value and the state expected one cycle later.
    rv.push_back(0);    sv.push_back(0);
    rv.push_back(100);  sv.push_back(1);
    repeat (5) begin rv.push_back(8192); sv.push_back(2); end
    rv.push_back(4000); sv.push_back(3);
    for (int k = 1; k <= DH; k++) begin rv.push_back(0); sv.push_back(k == DH ? 4 : 3); end
    rv.push_back(0);    sv.push_back(4);
    rv.push_back(50);   sv.push_back(1);
    rv.push_back(9000); sv.push_back(2);
    rv.push_back(4000); sv.push_back(3);
    for (int k = 1; k < DH; k++) begin rv.push_back(0); sv.push_back(3); end
    rv.push_back(10);   sv.push_back(3);
    for (int k = 1; k < DH; k++) begin rv.push_back(0); sv.push_back(3); end
    rv.push_back(0);    sv.push_back(4);
    for (int i = 0; i < rv.size(); i++) begin
      ramp = RW'(rv[i]);
      step();
      chk("env_state", ramp_state, sv[i]);
      chk("env_done", ramp_done, (sv[i] == 4) ? 1 : 0);
    end

    // Directed datapath beats with latency checking.
    lat_chk = 1'b1;
    m_axis_tready = 1'b1;
    send(1000, 8192);
    send(-32768, 8192);
    send(32767, 8192);
    send(3, 4096);
    send(-3, 4096);
    send(20000, 9000);
    send(-20000, 65535);
    send(12345, 0);
    s_axis_tvalid = 1'b0;
    wait_drain();
    lat_chk = 1'b0;

    // Randomized stream with bubbles and backpressure.
    acc = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!s_axis_tvalid || acc) begin
        s_axis_tvalid = ($urandom % 4) != 0;
        s_axis_tdata  = DW'($urandom);
        sel = $urandom_range(0, 4);
        case (sel)
          0:       ramp = '0;
          1:       ramp = RW'(8192);
          2:       ramp = RW'($urandom_range(8193, 65535));
          default: ramp = RW'($urandom_range(0, 8192));
        endcase
      end
      m_axis_tready = ($urandom % 3) != 0;
      #1;
      acc = s_axis_tvalid && s_axis_tready;
      step();
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    wait_drain();

    // Reset with a full pipeline while the envelope sits at FULL.
    ramp = RW'(8192);
    m_axis_tready = 1'b0;
    repeat (3) step();
    chk("pre_rst_state", ramp_state, 2);
    send(111, 8192);
    send(-222, 8192);
    send(333, 8192);
    s_axis_tvalid = 1'b0;
    chk("inflight_valid", m_axis_tvalid, 1);
    reset = 1'b1;
    step();
    exp_q.delete();
    chk("flush_mvalid", m_axis_tvalid, 0);
    chk("flush_mdata", m_axis_tdata, 0);
    chk("flush_state", ramp_state, 0);
    chk("flush_done", ramp_done, 0);
    reset = 1'b0;
    m_axis_tready = 1'b1;
    step();

    // Recovery after flush.
    lat_chk = 1'b1;
    send(-4000, 2048);
    send(7, 4096);
    s_axis_tvalid = 1'b0;
    wait_drain();
    lat_chk = 1'b0;
    repeat (5) step();
    chk("no_stray_beats", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
